sdram_model: RTL

SDRAM_MODEL -- requirements
Module: sdram_model

---
 rtl/sdram_model.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sdram_model.sv
// Cycle-level behavioural SDRAM model: 4 banks, burst length 1, CL 2 or 3.
// Define SDRAM_MODEL_ERRCHK_EN to build the sticky protocol-error checker.
module sdram_model #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  dram_ba,
    input  logic [12:0] dram_addr,
    input  logic        dram_ras,
    input  logic        dram_cas,
    input  logic        dram_we,
    input  logic        dram_ldqm,
    input  logic        dram_udqm,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe,
    output logic [3:0]  bank_open,
    output logic        err
);
    localparam int AW = 2 + ROW_BITS + COL_BITS;

    localparam logic [2:0] CMD_LMR    = 3'b000;
    localparam logic [2:0] CMD_REF    = 3'b001;
    localparam logic [2:0] CMD_PRE    = 3'b010;
    localparam logic [2:0] CMD_ACTIVE = 3'b011;
    localparam logic [2:0] CMD_WRITE  = 3'b100;
    localparam logic [2:0] CMD_READ   = 3'b101;

    logic [15:0]         mem [0:(1 << AW) - 1];
    logic [ROW_BITS-1:0] open_row [0:3];
    logic                cl3;

    logic [2:0]          cmd;
    logic                is_rd;
    logic                is_wr;
    logic                rd_en;
    logic [ROW_BITS-1:0] acc_row;
    logic [AW-1:0]       idx;
    logic [15:0]         cur;
    logic [15:0]         wr_word;

    // p1 is the extra stage used only when CL=3; p0 feeds the output register.
    logic                p0_v, p1_v;
    logic [15:0]         p0_d, p1_d;

    logic                unused_addr;

    always_comb begin
        cmd     = {dram_ras, dram_cas, dram_we};
        is_rd   = !reset && (cmd == CMD_READ);
        is_wr   = !reset && (cmd == CMD_WRITE);
        rd_en   = is_rd && !(dram_ldqm && dram_udqm);
        // An access to a closed bank falls back to row 0.
        acc_row = bank_open[dram_ba] ? open_row[dram_ba] : '0;
        idx     = {dram_ba, acc_row, dram_addr[COL_BITS-1:0]};
        cur     = mem[idx];
        wr_word = {dram_udqm ? cur[15:8] : dq_i[15:8],
                   dram_ldqm ? cur[7:0]  : dq_i[7:0]};
    end

    assign unused_addr = &{1'b0, dram_addr};

    always_ff @(posedge clock) begin
        if (is_wr) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dq_o      <= '0;
            dq_oe     <= 1'b0;
            bank_open <= '0;
            cl3       <= 1'b0;
            p0_v      <= 1'b0;
            p0_d      <= '0;
            p1_v      <= 1'b0;
            p1_d      <= '0;
        end else begin
            dq_o  <= p0_v ? p0_d : '0;
            dq_oe <= p0_v;
            p0_v  <= p1_v;
            p0_d  <= p1_d;
            p1_v  <= 1'b0;
            if (is_rd) begin
                if (cl3) begin
                    p1_v <= rd_en;
                    p1_d <= cur;
                end else begin
                    p0_v <= rd_en;
                    p0_d <= cur;
                end
            end
            case (cmd)
                CMD_ACTIVE: begin
                    bank_open[dram_ba] <= 1'b1;
                    open_row[dram_ba]  <= dram_addr[ROW_BITS-1:0];
                end
                CMD_PRE: begin
                    if (dram_addr[10]) bank_open <= '0;
                    else               bank_open[dram_ba] <= 1'b0;
                end
                CMD_READ, CMD_WRITE: begin
                    if (dram_addr[10]) bank_open[dram_ba] <= 1'b0;
                end
                CMD_LMR: cl3 <= (dram_addr[6:4] == 3'd3);
                default: ;
            endcase
        end
    end

`ifdef SDRAM_MODEL_ERRCHK_EN
    logic err_hit;

    always_comb begin
        err_hit = 1'b0;
        case (cmd)
            CMD_READ:   err_hit = !bank_open[dram_ba];
            CMD_WRITE:  err_hit = !bank_open[dram_ba] || dq_oe;
            CMD_ACTIVE: err_hit = bank_open[dram_ba];
            CMD_REF:    err_hit = |bank_open;
            default:    err_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)        err <= 1'b0;
        else if (err_hit) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
